instr_fetch_ctrl: RTL

//  Sequences the 16-bit word-addressed instruction memory: owns the PC, drives
//  A_InstrAddress/C_IMRead, captures D_Instruction (combinational read) into a small

---
 rtl/instr_fetch_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// instr_fetch_ctrl
//   Instruction fetch sequencer between a 16-bit word-addressed IMEM and decode.
//   Owns the PC, strobes IMEM (combinational read), buffers fetched words in a
//   small queue and hands them to decode over a valid/ready handshake. Handles
//   branch redirect (queue flush, PC reload) and stops fetching once the halt
//   encoding has been enqueued.
//
//   Optional feature macro: FETCH_PERF_CNT_EN adds saturating stall/fetch
//   counters (D_StallCount, D_FetchCount). Without it those ports do not exist.
//
// Ports
//   clk               in   clock, all state on rising edge
//   rst               in   synchronous active-high reset
//   C_FetchEn         in   permit fetching / leave IDLE
//   C_Redirect        in   1-cycle pulse: flush queue, PC <= A_RedirectTarget
//   A_RedirectTarget  in   redirect word address
//   D_Instruction     in   IMEM read data, valid in the C_IMRead cycle
//   A_InstrAddress    out  IMEM address (the PC register)
//   C_IMRead          out  IMEM read strobe
//   D_InstrOut        out  queue head instruction
//   A_InstrPC         out  PC of queue head
//   C_InstrValid      out  queue non-empty
//   C_DecodeReady     in   decode accepts head when C_InstrValid is high
//   C_Halted          out  controller is in HALT
//   C_RedirectFault   out  sticky: out-of-range redirect target seen
//   D_StallCount      out  (FETCH_PERF_CNT_EN) FETCH cycles stalled on full queue
//   D_FetchCount      out  (FETCH_PERF_CNT_EN) instructions pushed
// -----------------------------------------------------------------------------
module instr_fetch_ctrl #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int          IMEM_WORDS = 8192,
    parameter int          FQ_DEPTH   = 2,
    parameter logic [15:0] HALT_INSTR = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        C_FetchEn,
    input  logic        C_Redirect,
    input  logic [15:0] A_RedirectTarget,
    input  logic [15:0] D_Instruction,
    output logic [15:0] A_InstrAddress,
    output logic        C_IMRead,
    output logic [15:0] D_InstrOut,
    output logic [15:0] A_InstrPC,
    output logic        C_InstrValid,
    input  logic        C_DecodeReady,
    output logic        C_Halted,
    output logic        C_RedirectFault
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] D_StallCount,
    output logic [31:0] D_FetchCount
`endif
);

    localparam int PTR_W = $clog2(FQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_HALT} state_t;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
    } entry_t;

    state_t           state, state_nxt;
    logic [15:0]      pc;
    entry_t           fq_mem [FQ_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    entry_t           head_hold;
    logic             fault;

    logic             empty, full, push, pop;
    entry_t           head;
    logic [15:0]      pc_inc;
    logic [15:0]      tgt_wrapped;
    logic             tgt_oob;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(FQ_DEPTH));
    assign pop   = !empty && C_DecodeReady;

    // A pop in the same cycle frees a slot, so a full queue can still accept
    // a fetch and sustain one instruction per cycle.
    assign C_IMRead = !rst && (state == ST_FETCH) && !C_Redirect && (!full || pop);
    assign push     = C_IMRead;

    assign pc_inc      = (pc == 16'(IMEM_WORDS - 1)) ? 16'h0000 : pc + 16'd1;
    assign tgt_wrapped = 16'(32'(A_RedirectTarget) % 32'(IMEM_WORDS));
    assign tgt_oob     = (32'(A_RedirectTarget) >= 32'(IMEM_WORDS));

    // When empty, present the last head seen so the outputs never depend on
    // uninitialised queue storage.
    assign head = empty ? head_hold : fq_mem[rd_ptr];

    assign A_InstrAddress  = pc;
    assign D_InstrOut      = head.instr;
    assign A_InstrPC       = head.pc;
    assign C_InstrValid    = !empty;
    assign C_Halted        = (state == ST_HALT);
    assign C_RedirectFault = fault;

    always_comb begin
        // NOTE: default assigned first so every path drives state_nxt; a
        // missing branch would otherwise infer a latch.
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (C_FetchEn) state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (C_Redirect)
                    state_nxt = ST_FETCH;
                else if (push && (D_Instruction == HALT_INSTR))
                    state_nxt = ST_HALT;
                else if (!C_FetchEn)
                    state_nxt = ST_IDLE;
            end
            ST_HALT:  if (C_Redirect) state_nxt = ST_FETCH;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            pc        <= RESET_PC;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            head_hold <= '0;
            fault     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (!empty)
                head_hold <= fq_mem[rd_ptr];
            if (C_Redirect) begin
                // Redirect wins over push/pop: discard everything in flight.
                pc     <= tgt_wrapped;
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
                if (tgt_oob)
                    fault <= 1'b1;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    pc     <= pc_inc;
                end
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                unique case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // NOTE: queue storage has no reset; an entry is only read after it has
    // been written, and the empty case is served from head_hold.
    always_ff @(posedge clk) begin
        if (push)
            fq_mem[wr_ptr] <= '{instr: D_Instruction, pc: pc};
    end

`ifdef FETCH_PERF_CNT_EN
    logic stall_evt;

    // A stall is a FETCH cycle where the read is held off by a full queue;
    // redirect cycles are not stalls.
    assign stall_evt = (state == ST_FETCH) && !C_Redirect && !C_IMRead;

    always_ff @(posedge clk) begin
        if (rst) begin
            D_StallCount <= '0;
            D_FetchCount <= '0;
        end else begin
            if (stall_evt && (D_StallCount != 32'hFFFF_FFFF))
                D_StallCount <= D_StallCount + 32'd1;
            if (push && (D_FetchCount != 32'hFFFF_FFFF))
                D_FetchCount <= D_FetchCount + 32'd1;
        end
    end
`else
    // Performance counters not built.
`endif

endmodule
